tagged_fifo_bank: RTL

- Receiving end of the actor write protocol (write / din / full per flux).
- Accepts tagged words {tag, data} from one upstream actor and routes each word into one of FLUX independent FIFO queues, selected by the tag.
- Exposes per-flux empty/read/dout toward the downstream actor, so per-flux backpressure is local and fluxes never block each other.

---
 rtl/tagged_fifo_bank.sv | 133 +++++++++++++
 1 files changed

// File: rtl/tagged_fifo_bank.sv
// -----------------------------------------------------------------------------
// tagged_fifo_bank
//
// Receiving end of a tagged write stream. Each incoming word {tag, data} is
// routed into one of FLUX independent first-word-fall-through queues chosen by
// its tag. Each queue has its own pointers, occupancy count and flags, so a
// stalled consumer on one queue never blocks writes to another.
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous reset, active low
//   write    upstream write strobe
//   din      {tag, data}; tag occupies din[WIDTH-1:DATA_WIDTH]
//   full     full[i]  = queue i holds DEPTH words (registered decode)
//   read     read[i]  pops the head of queue i
//   empty    empty[i] = queue i holds no words (registered decode)
//   dout     head word of queue i at [i*WIDTH +: WIDTH], tag included
//   count    occupancy of queue i at [i*CW +: CW], CW = $clog2(DEPTH)+1
//
// Optional build macro TAGGED_FIFO_BANK_ERR_EN adds:
//   err_clr  synchronous clear of the sticky error bits
//   err      {bad_tag, underflow, overflow}, sticky; a new event in the same
//            cycle as err_clr wins over the clear
// Without the macro, dropped writes and ignored reads are silent.
// -----------------------------------------------------------------------------
module tagged_fifo_bank #(
    parameter int DATA_WIDTH = 8,
    parameter int FLUX       = 2,
    parameter int DEPTH      = 4,
    localparam int TAG_WIDTH = $clog2(FLUX),
    localparam int WIDTH     = DATA_WIDTH + TAG_WIDTH,
    localparam int PW        = $clog2(DEPTH),
    localparam int CW        = PW + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write,
    input  logic [WIDTH-1:0]      din,
    output logic [FLUX-1:0]       full,
    input  logic [FLUX-1:0]       read,
    output logic [FLUX-1:0]       empty,
    output logic [FLUX*WIDTH-1:0] dout,
`ifdef TAGGED_FIFO_BANK_ERR_EN
    input  logic                  err_clr,
    output logic [2:0]            err,
`endif
    output logic [FLUX*CW-1:0]    count
);

    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [TAG_WIDTH-1:0] tag;
    logic [FLUX-1:0]      sel;

    assign tag = din[WIDTH-1:DATA_WIDTH];

    for (genvar g = 0; g < FLUX; g++) begin : g_queue
        logic [PW-1:0]    wptr;
        logic [PW-1:0]    rptr;
        logic [CW-1:0]    cnt;
        logic [WIDTH-1:0] mem [DEPTH];
        logic             do_wr;
        logic             do_rd;

        // A tag >= FLUX never matches any g, so invalid tags fall out here.
        assign sel[g]   = write && (tag == TAG_WIDTH'(g));

        // Acceptance uses the registered count only, so an accepted read in
        // the same cycle does not make room for a write to a full queue, and
        // a write into an empty queue does not allow a same-cycle read.
        assign full[g]  = (cnt == CNT_FULL);
        assign empty[g] = (cnt == '0);
        assign do_wr    = sel[g] && !full[g];
        assign do_rd    = read[g] && !empty[g];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                wptr <= '0;
                rptr <= '0;
                cnt  <= '0;
            end else begin
                if (do_wr) begin
                    wptr <= wptr + 1'b1;
                end
                if (do_rd) begin
                    rptr <= rptr + 1'b1;
                end
                case ({do_wr, do_rd})
                    2'b10:   cnt <= cnt + 1'b1;
                    2'b01:   cnt <= cnt - 1'b1;
                    default: cnt <= cnt;
                endcase
            end
        end

        // Storage is deliberately left out of reset.
        always_ff @(posedge clk) begin
            if (do_wr) begin
                mem[wptr] <= din;
            end
        end

        // Head word falls through combinationally. It is forced to zero while
        // the queue is empty so that stale storage never shows after reset.
        assign dout[g*WIDTH +: WIDTH] = empty[g] ? '0 : mem[rptr];
        assign count[g*CW +: CW]      = cnt;
    end

`ifdef TAGGED_FIFO_BANK_ERR_EN
    localparam logic [TAG_WIDTH:0] FLUX_LIM = (TAG_WIDTH+1)'(FLUX);

    logic       tag_valid;
    logic       evt_bad_tag;
    logic       evt_underflow;
    logic       evt_overflow;
    logic [2:0] evt;

    assign tag_valid     = ({1'b0, tag} < FLUX_LIM);
    assign evt_bad_tag   = write && !tag_valid;
    assign evt_underflow = |(read & empty);
    assign evt_overflow  = |(sel & full);
    assign evt           = {evt_bad_tag, evt_underflow, evt_overflow};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= '0;
        end else begin
            err <= (err_clr ? 3'b000 : err) | evt;
        end
    end
`endif

endmodule
